pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
// Central stall/flush controller for the 5-stage core. Drives the enable/flush pair of every
// pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC enable.
// Resolves load-use hazards, taken-branch squashes, main-memory wait states and HALT.
// Sequences run/idle/halt so the core starts only on an external start pulse.
// PARAMETERS
// MEM_WAIT   2   extra cycles per main-memory access (1..15); used only with PIPE_MEM_WAIT_EN
// PORTS
// clk               in   1   core clock
// reset             in   1   asynchronous, active-high reset
// start             in   1   1-cycle pulse; leaves IDLE/HALTED
// rs_adr_id         in   3   source reg A of instr in ID
// rt_adr_id         in   3   source reg B of instr in ID
// rs_used_id        in   1   ID instr reads rs
// rt_used_id        in   1   ID instr reads rt
// main_mem_read_ex  in   1   instr in EX is a load
// regwrite_adr_ex   in   3   destination reg of instr in EX
// branch_taken_ex   in   1   branch in EX resolved taken
// main_mem_read     in   1   MEM-stage load
// main_mem_write    in   1   MEM-stage store
// is_halt           in   1   HALT instr in MEM
// en_pc             out  1   PC load enable
// en_ifid,flush_ifid      out 1,1  IF/ID controls
// en_idex,flush_idex      out 1,1  ID/EX controls
// en_exmem,flush_exmem    out 1,1  EX/MEM controls
// en_memwb,flush_memwb    out 1,1  MEM/WB controls
// running           out  1   state is RUN or MWAIT
// halted            out  1   state is HALTED
// stall_cnt         out  16  saturating count of stall cycles since reset
// BEHAVIOUR
// - States: IDLE (reset), RUN, MWAIT, HALTED. Controls are combinational from state + inputs.
// - Reset (async): state=IDLE, wait cnt=0, stall_cnt=0. All en_*=0, flush_*=0, running=0, halted=0.
// - IDLE/HALTED: all en_*=0 and flush_*=0 (pipe frozen).
//   start=1 -> RUN on the next edge. start is ignored in RUN/MWAIT.
// - RUN: priority, highest first:
//   1 is_halt: en_pc=0; flush_ifid=flush_idex=flush_exmem=1; en_memwb=1 -> HALTED.
//   2 mem access (read|write) with PIPE_MEM_WAIT_EN: all en_*=0, flushes 0;
//     cnt<=MEM_WAIT-1 -> MWAIT.
//   3 branch_taken_ex: all en_*=1; flush_ifid=flush_idex=1 (overrides load-use).
//   4 load-use: main_mem_read_ex & regwrite_adr_ex matches a used source
//     (rs_adr_id&rs_used_id | rt_adr_id&rt_used_id):
//     en_pc=en_ifid=0; flush_idex=1; en_exmem=en_memwb=1.
//   5 else: all en_*=1, all flush_*=0.
// - MWAIT: cnt!=0 -> all en_*=0, cnt decrements. cnt==0 -> apply RUN rules 1,3,4,5
//   (not 2; the access is served) -> RUN.
//   Total extra latency per access = MEM_WAIT cycles.
// - stall_cnt +1 on every RUN/MWAIT cycle with en_pc=0 and no halt; holds at 16'hFFFF.
// - Back-to-back memory accesses each pay MEM_WAIT; halt in MEM during MWAIT acts at cnt==0.
// CONFIGURATION
// PIPE_MEM_WAIT_EN defined: rule 2 and MWAIT active; MEM_WAIT is honoured.
// Undefined: memory is single-cycle; MWAIT is unreachable and MEM_WAIT is ignored.
// TESTING
// 1 load r3 in EX, ID reads rt=r3 used -> one cycle en_pc=en_ifid=0, flush_idex=1; stall_cnt=1
// 2 load r3 in EX, ID uses r3, branch_taken_ex=1 same cycle -> en_*=1, flush_ifid=flush_idex=1, no stall
// 3 EN, MEM_WAIT=2, store in MEM -> en_* low for exactly 2 cycles, then advance; stall_cnt=2
// 4 is_halt=1 in RUN -> flush_ifid/idex/exmem=1, en_memwb=1; next halted=1; start -> RUN in 1 cycle
// 5 reset asserted mid-MWAIT -> immediately IDLE, all outputs 0, stall_cnt=0; start resumes RUN
// 6 macro undefined, load in MEM -> no freeze; en_*=1 every cycle

Source files
------------

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage core: IDLE/RUN/MWAIT/HALTED sequencing and hazard control.
// Optional main-memory wait states are enabled by defining PIPE_MEM_WAIT_EN.
module pipe_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  rs_adr_id,
  input  logic [2:0]  rt_adr_id,
  input  logic        rs_used_id,
  input  logic        rt_used_id,
  input  logic        main_mem_read_ex,
  input  logic [2:0]  regwrite_adr_ex,
  input  logic        branch_taken_ex,
  input  logic        main_mem_read,
  input  logic        main_mem_write,
  input  logic        is_halt,
  output logic        en_pc,
  output logic        en_ifid,
  output logic        flush_ifid,
  output logic        en_idex,
  output logic        flush_idex,
  output logic        en_exmem,
  output logic        flush_exmem,
  output logic        en_memwb,
  output logic        flush_memwb,
  output logic        running,
  output logic        halted,
  output logic [15:0] stall_cnt
);

`ifdef PIPE_MEM_WAIT_EN
  localparam logic WAIT_EN = 1'b1;
`else
  localparam logic WAIT_EN = 1'b0;
`endif
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    MWAIT  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       halt_act;
  logic       load_use;
  logic       mem_acc;

  assign mem_acc  = main_mem_read | main_mem_write;
  assign load_use = main_mem_read_ex &
                    ((rs_used_id & (rs_adr_id == regwrite_adr_ex)) |
                     (rt_used_id & (rt_adr_id == regwrite_adr_ex)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    en_pc       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    halt_act    = 1'b0;
    state_next  = state;
    cnt_next    = cnt;
    case (state)
      IDLE, HALTED: begin
        if (start) state_next = RUN;
        else       state_next = state;
      end
      RUN, MWAIT: begin
        if (state == MWAIT && cnt != 4'd0) begin
          // Access still outstanding: whole pipe frozen.
          cnt_next = cnt - 4'd1;
        end else if (is_halt) begin
          en_ifid     = 1'b1;
          en_idex     = 1'b1;
          en_exmem    = 1'b1;
          en_memwb    = 1'b1;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
          halt_act    = 1'b1;
          state_next  = HALTED;
        end else if (WAIT_EN && state == RUN && mem_acc) begin
          cnt_next   = WAIT_INIT;
          state_next = MWAIT;
        end else if (branch_taken_ex) begin
          en_pc      = 1'b1;
          en_ifid    = 1'b1;
          en_idex    = 1'b1;
          en_exmem   = 1'b1;
          en_memwb   = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_next = RUN;
        end else if (load_use) begin
          // Hold PC and IF/ID, inject a bubble into ID/EX.
          en_idex    = 1'b1;
          en_exmem   = 1'b1;
          en_memwb   = 1'b1;
          flush_idex = 1'b1;
          state_next = RUN;
        end else begin
          en_pc      = 1'b1;
          en_ifid    = 1'b1;
          en_idex    = 1'b1;
          en_exmem   = 1'b1;
          en_memwb   = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign running = (state == RUN) || (state == MWAIT);
  assign halted  = (state == HALTED);

  // Saturating count of cycles in which the PC was held for a hazard or wait state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (running && !en_pc && !halt_act && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl; expectations follow the PIPE_MEM_WAIT_EN setting.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  rs_adr_id, rt_adr_id, regwrite_adr_ex;
  logic        rs_used_id, rt_used_id, main_mem_read_ex, branch_taken_ex;
  logic        main_mem_read, main_mem_write, is_halt;
  logic        en_pc, en_ifid, flush_ifid, en_idex, flush_idex;
  logic        en_exmem, flush_exmem, en_memwb, flush_memwb, running, halted;
  logic [15:0] stall_cnt;

  pipe_ctrl #(.MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rs_adr_id(rs_adr_id), .rt_adr_id(rt_adr_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .main_mem_read_ex(main_mem_read_ex), .regwrite_adr_ex(regwrite_adr_ex),
    .branch_taken_ex(branch_taken_ex),
    .main_mem_read(main_mem_read), .main_mem_write(main_mem_write),
    .is_halt(is_halt),
    .en_pc(en_pc), .en_ifid(en_ifid), .flush_ifid(flush_ifid),
    .en_idex(en_idex), .flush_idex(flush_idex),
    .en_exmem(en_exmem), .flush_exmem(flush_exmem),
    .en_memwb(en_memwb), .flush_memwb(flush_memwb),
    .running(running), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {en_pc,en_ifid,en_idex,en_exmem,en_memwb, flush_ifid,flush_idex,flush_exmem,flush_memwb, running,halted}
  localparam logic [10:0] C_FROZEN = 11'b00000_0000_00;
  localparam logic [10:0] C_RUN    = 11'b11111_0000_10;
  localparam logic [10:0] C_LU     = 11'b00111_0100_10;
  localparam logic [10:0] C_BR     = 11'b11111_1100_10;
  localparam logic [10:0] C_HALT   = 11'b01111_1110_10;
  localparam logic [10:0] C_WAIT   = 11'b00000_0000_10;
  localparam logic [10:0] C_HALTED = 11'b00000_0000_01;

  logic [10:0] obs;
  assign obs = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                flush_ifid, flush_idex, flush_exmem, flush_memwb, running, halted};

  logic [26:0] sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          sc    = 0;

  task automatic clr();
    start = 1'b0; rs_adr_id = 3'd0; rt_adr_id = 3'd0; regwrite_adr_ex = 3'd0;
    rs_used_id = 1'b0; rt_used_id = 1'b0; main_mem_read_ex = 1'b0; branch_taken_ex = 1'b0;
    main_mem_read = 1'b0; main_mem_write = 1'b0; is_halt = 1'b0;
  endtask

  task automatic step(input string tag, input logic [10:0] ctl, input int sc_exp);
    logic [26:0] e;
    sb_q.push_back({ctl, sc_exp[15:0]});
    @(negedge clk);
    e = sb_q.pop_front();
    tests++;
    assert (obs === e[26:16]) else begin
      fails++;
      $error("FAIL %s ctrl: got %b expected %b", tag, obs, e[26:16]);
    end
    tests++;
    assert (stall_cnt === e[15:0]) else begin
      fails++;
      $error("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, e[15:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    step("reset", C_FROZEN, 0);
    reset = 1'b0;
    step("idle", C_FROZEN, 0);
    main_mem_read_ex = 1'b1; regwrite_adr_ex = 3'd3; rt_adr_id = 3'd3; rt_used_id = 1'b1;
    step("idle_hazard", C_FROZEN, 0);
    clr(); start = 1'b1;
    step("start", C_FROZEN, 0);
    step("run_start_ignored", C_RUN, 0);
    clr(); main_mem_read_ex = 1'b1; regwrite_adr_ex = 3'd3; rt_adr_id = 3'd3; rt_used_id = 1'b1;
    step("load_use_rt", C_LU, 0);
    clr(); sc = 1;
    step("after_load_use", C_RUN, sc);
    main_mem_read_ex = 1'b1; regwrite_adr_ex = 3'd3; rs_adr_id = 3'd3; rs_used_id = 1'b0;
    step("load_rs_unused", C_RUN, sc);
    clr(); main_mem_read_ex = 1'b1; regwrite_adr_ex = 3'd5; rs_adr_id = 3'd5; rs_used_id = 1'b1;
    branch_taken_ex = 1'b1;
    step("branch_over_lu", C_BR, sc);
    main_mem_read_ex = 1'b0; branch_taken_ex = 1'b0;
    step("no_load_ex", C_RUN, sc);
    clr(); main_mem_write = 1'b1;
`ifdef PIPE_MEM_WAIT_EN
    step("store_run", C_WAIT, sc);
    sc++;
    step("store_mwait", C_WAIT, sc);
    sc++;
    step("store_done", C_RUN, sc);
    clr(); main_mem_read = 1'b1;
    step("load_run", C_WAIT, sc);
    sc++;
    step("load_mwait", C_WAIT, sc);
    sc++;
    step("load_done", C_RUN, sc);
`else
    step("store_nowait", C_RUN, sc);
    clr(); main_mem_read = 1'b1;
    step("load_nowait", C_RUN, sc);
`endif
    clr(); is_halt = 1'b1;
    step("halt", C_HALT, sc);
    clr();
    step("halted", C_HALTED, sc);
    start = 1'b1;
    step("halted_start", C_HALTED, sc);
    clr();
    step("resume", C_RUN, sc);
    main_mem_write = 1'b1;
`ifdef PIPE_MEM_WAIT_EN
    step("store2_run", C_WAIT, sc);
    sc++;
`else
    step("store2_nowait", C_RUN, sc);
`endif
    reset = 1'b1;
    step("reset_mid", C_FROZEN, 0);
    sc = 0;
    reset = 1'b0; clr();
    step("post_reset_idle", C_FROZEN, 0);
    start = 1'b1;
    step("restart", C_FROZEN, 0);
    clr();
    step("rerun", C_RUN, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
